// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - core data-port to single-outstanding bus controller with timeout
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        clock__i,
    input  logic        reset_n__i,
    input  logic [31:0] memAddr__i,
    input  logic [31:0] memDataWrite__i,
    input  logic        memRead__i,
    input  logic        memWrite__i,
    output logic [31:0] memDataRead__o,
    output logic        memStall__o,
    output logic        busReq__o,
    output logic        busWe__o,
    output logic [31:0] busAddr__o,
    output logic [31:0] busWData__o,
    input  logic        busAck__i,
    input  logic [31:0] busRData__i,
    input  logic        errClear__i,
    output logic        alignErr__o,
    output logic        timeoutErr__o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Timeout fires in the REQ cycle whose incoming count is TIMEOUT_CYCLES-1,
    // so the request is held for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        align_err_q, align_err_d;
    logic        timeout_err_q, timeout_err_d;

    logic        req_any;
    logic        req_aligned;
    logic        new_align_err;
    logic        new_timeout_err;

    assign req_any     = memRead__i | memWrite__i;
    assign req_aligned = (memAddr__i[1:0] == 2'b00);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus_req_d       = bus_req_q;
        bus_we_d        = bus_we_q;
        bus_addr_d      = bus_addr_q;
        bus_wdata_d     = bus_wdata_q;
        rdata_d         = rdata_q;
        new_align_err   = 1'b0;
        new_timeout_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if (req_aligned) begin
                        state_d     = ST_REQ;
                        cnt_d       = 8'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = memWrite__i;
                        bus_addr_d  = memAddr__i;
                        bus_wdata_d = memDataWrite__i;
                    end else begin
                        new_align_err = 1'b1;
                        // Store takes priority when both strobes are high.
                        if (!memWrite__i) begin
                            rdata_d = 32'd0;
                        end
                    end
                end
            end

            ST_REQ: begin
                if (busAck__i) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d = busRData__i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = ST_DONE;
                    bus_req_d       = 1'b0;
                    new_timeout_err = 1'b1;
                    if (!bus_we_q) begin
                        rdata_d = TIMEOUT_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        align_err_d   = (align_err_q & ~errClear__i) | new_align_err;
        timeout_err_d = (timeout_err_q & ~errClear__i) | new_timeout_err;
    end

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            rdata_q       <= 32'd0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            align_err_q   <= align_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Stall must rise in the same cycle the core presents the access.
    assign memStall__o = ((state_q == ST_IDLE) && req_any && req_aligned) ||
                         (state_q == ST_REQ);

    assign busReq__o      = bus_req_q;
    assign busWe__o       = bus_we_q;
    assign busAddr__o     = bus_addr_q;
    assign busWData__o    = bus_wdata_q;
    assign memDataRead__o = rdata_q;
    assign alignErr__o    = align_err_q;
    assign timeoutErr__o  = timeout_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err_clear;
    logic        align_err;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(
        .TIMEOUT_CYCLES(4),
        .TIMEOUT_DATA  (32'hFFFF_FFFF)
    ) dut (
        .clock__i       (clk),
        .reset_n__i     (rst_n),
        .memAddr__i     (mem_addr),
        .memDataWrite__i(mem_wdata),
        .memRead__i     (mem_rd),
        .memWrite__i    (mem_wr),
        .memDataRead__o (mem_rdata),
        .memStall__o    (mem_stall),
        .busReq__o      (bus_req),
        .busWe__o       (bus_we),
        .busAddr__o     (bus_addr),
        .busWData__o    (bus_wdata),
        .busAck__i      (bus_ack),
        .busRData__i    (bus_rdata),
        .errClear__i    (err_clear),
        .alignErr__o    (align_err),
        .timeoutErr__o  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_rd = 1'b0; mem_wr = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'd0; err_clear = 1'b0;
        tick; tick;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req got %h exp 0", bus_req); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_we got %h exp 0", bus_we); end
        checks++; if (bus_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus_addr); end
        checks++; if (bus_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus_wdata); end
        checks++; if (mem_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", mem_rdata); end
        checks++; if (align_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", align_err, timeout_err); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall_idle got %h exp 0", mem_stall); end
        mem_rd = 1'b1; #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rst_stall_req got %h exp 1", mem_stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req_held got %h exp 0", bus_req); end
        mem_rd = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_read;
        tick;
        mem_addr = 32'h100; mem_rd = 1'b1; #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_n got %h exp 1", mem_stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rd_req_n got %h exp 0", bus_req); end
        tick;
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL rd_req_we got %b%b exp 10", bus_req, bus_we); end
        checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %h exp 00000100", bus_addr); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_n1 got %h exp 1", mem_stall); end
        tick;
        bus_ack = 1'b0; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rd_stall_done got %h exp 0", mem_stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rd_req_done got %h exp 0", bus_req); end
        checks++; if (mem_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data got %h exp cafef00d", mem_rdata); end
        mem_rd = 1'b0;
        tick;
        checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rd_idle got %b%b exp 00", bus_req, mem_stall); end
        checks++; if (mem_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_hold got %h exp cafef00d", mem_rdata); end
    endtask

    task automatic test_write;
        mem_addr = 32'h204; mem_wdata = 32'h12345678; mem_wr = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin mem_wdata = 32'h0; mem_addr = 32'h0; #1; end
            checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("FAIL wr_ctl[%0d] got %b%b%b exp 111", i, bus_req, bus_we, mem_stall); end
            checks++; if (bus_addr !== 32'h204 || bus_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_bus[%0d] got %h %h exp 00000204 12345678", i, bus_addr, bus_wdata); end
            if (i == 3) bus_ack = 1'b1;
            tick;
        end
        bus_ack = 1'b0; #1;
        checks++; if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL wr_done got %b%b exp 00", mem_stall, bus_req); end
        checks++; if (mem_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_rdata got %h exp cafef00d", mem_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wr_terr got %h exp 0", timeout_err); end
        mem_wr = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        mem_addr = 32'h300; mem_rd = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d] got %h exp 1", i, bus_req); end
            tick;
        end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %h exp 0", bus_req); end
        checks++; if (mem_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL to_data got %h exp ffffffff", mem_rdata); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %h exp 1", timeout_err); end
        mem_rd = 1'b0;
        tick;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %h exp 1", timeout_err); end
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0; #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %h exp 0", timeout_err); end
    endtask

    task automatic test_misaligned;
        mem_addr = 32'h102; mem_rd = 1'b1; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %h exp 0", mem_stall); end
        tick;
        mem_rd = 1'b0; #1;
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL mis_err got %h exp 1", align_err); end
        checks++; if (mem_rdata !== 32'd0) begin errors++; $display("FAIL mis_data got %h exp 0", mem_rdata); end
        checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL mis_bus got %b%b exp 00", bus_req, mem_stall); end
        mem_addr = 32'h101; mem_wr = 1'b1; err_clear = 1'b1;
        tick;
        mem_wr = 1'b0; err_clear = 1'b0; #1;
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL mis_set_wins got %h exp 1", align_err); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mis_wr_req got %h exp 0", bus_req); end
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0; #1;
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL mis_clear got %h exp 0", align_err); end
    endtask

    task automatic test_ack_outside;
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        tick;
        bus_ack = 1'b0; #1;
        checks++; if (mem_rdata !== 32'd0) begin errors++; $display("FAIL ackout_data got %h exp 0", mem_rdata); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ackout_req got %h exp 0", bus_req); end
    endtask

    task automatic test_ack_in_timeout_cycle;
        mem_addr = 32'h500; mem_rd = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin bus_ack = 1'b1; bus_rdata = 32'h0BADBEEF; end
            tick;
        end
        bus_ack = 1'b0; #1;
        checks++; if (mem_rdata !== 32'h0BADBEEF) begin errors++; $display("FAIL ackto_data got %h exp 0badbeef", mem_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ackto_err got %h exp 0", timeout_err); end
        mem_rd = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_req;
        mem_addr = 32'h400; mem_rd = 1'b1;
        tick;
        tick;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_pre got %h exp 1", bus_req); end
        rst_n = 1'b0; #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %h exp 0", bus_req); end
        checks++; if (bus_addr !== 32'd0 || bus_we !== 1'b0 || bus_wdata !== 32'd0) begin errors++; $display("FAIL rmid_bus got %h %b %h exp 0 0 0", bus_addr, bus_we, bus_wdata); end
        checks++; if (mem_rdata !== 32'd0) begin errors++; $display("FAIL rmid_data got %h exp 0", mem_rdata); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rmid_stall got %h exp 1", mem_stall); end
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin errors++; $display("FAIL rmid_new got %b %h exp 1 00000400", bus_req, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
        tick;
        bus_ack = 1'b0; mem_rd = 1'b0; #1;
        checks++; if (mem_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rmid_data2 got %h exp a5a5a5a5", mem_rdata); end
        tick;
    endtask

    task automatic test_back_to_back;
        mem_addr = 32'h600; mem_rd = 1'b1;
        tick;
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        tick;
        bus_ack = 1'b0; mem_addr = 32'h604; #1;
        checks++; if (mem_rdata !== 32'h11111111) begin errors++; $display("FAIL b2b_data1 got %h exp 11111111", mem_rdata); end
        checks++; if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL b2b_done got %b%b exp 00", mem_stall, bus_req); end
        tick;
        checks++; if (mem_stall !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b%b exp 10", mem_stall, bus_req); end
        tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h604) begin errors++; $display("FAIL b2b_req2 got %b %h exp 1 00000604", bus_req, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h22222222;
        tick;
        bus_ack = 1'b0; mem_rd = 1'b0; #1;
        checks++; if (mem_rdata !== 32'h22222222) begin errors++; $display("FAIL b2b_data2 got %h exp 22222222", mem_rdata); end
        tick;
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_timeout;
        test_misaligned;
        test_ack_outside;
        test_ack_in_timeout_cycle;
        test_reset_mid_req;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
